seq_a_then_b_monitor: RTL and testbench
=======================================

// Module: seq_a_then_b_monitor
// PURPOSE
// Synthesizable run-time checker for the temporal property "a ##DELAY b", sampled on
// posedge clk. It is the evaluating end of the a/b stimulus interface: a new attempt
// starts every enabled cycle, and each attempt resolves to exactly one pass or fail.
// It keeps saturating pass/fail counters and timestamps the first failure.
// It sits beside the DUT in FPGA builds, where simulator assertions are unavailable.
// PARAMETERS
// DELAY   1    cycles between the a sample and the b sample (legal 1..15)
// CNT_W   16   width of pass_cnt / fail_cnt (saturating)
// TS_W    32   width of the free-running cycle timestamp
// PORTS
// clk              in   1      clock; all logic is on posedge
// rst              in   1      asynchronous, active-high reset
// en               in   1      1 = start a new attempt this cycle
// clr              in   1      synchronous clear of counters, pending attempts and first-fail
// a                in   1      sequence head signal
// b                in   1      sequence tail signal, checked DELAY cycles after a
// pass             out  1      registered pulse: at least one attempt passed at the last edge
// fail             out  1      registered pulse: at least one attempt failed at the last edge
// pass_cnt         out  CNT_W  total passes, saturating at all-ones
// fail_cnt         out  CNT_W  total failures, saturating at all-ones
// first_fail_vld   out  1      sticky; set at the first failure
// first_fail_time  out  TS_W   time_cnt value at the edge where the first failure was detected
// BEHAVIOUR
// - Reset: asserting rst drives every output and pend to 0 and time_cnt to 0,
//   asynchronously, at any point including mid-attempt. Pending attempts are discarded.
// - time_cnt is internal. It increments on every edge while rst=0 and wraps modulo 2^TS_W.
//   clr does not affect it.
// - pend[DELAY-1:0] is a shift register of attempts that sampled a=1. At each edge:
//   pend[0] <= en & a; pend[i] <= pend[i-1].
// - Resolution at edge k, with all inputs sampled at edge k:
//   * early_fail = en & ~a. The attempt fails immediately, with no wait for b.
//   * late_pass = pend[DELAY-1] & b. The attempt started at edge k-DELAY passes.
//   * late_fail = pend[DELAY-1] & ~b.
// - Outputs from edge k:
//   pass <= late_pass; fail <= early_fail | late_fail.
//   pass and fail may both be 1 in the same cycle (independent overlapping attempts).
// - Counters:
//   pass_cnt += late_pass; fail_cnt += early_fail + late_fail (0, 1 or 2 per edge).
//   Both saturate at 2^CNT_W-1 and never wrap.
// - First failure: on the first edge with any failure while first_fail_vld=0,
//   first_fail_time <= time_cnt and first_fail_vld <= 1. Later failures do not update it.
// - en=0: no new attempt starts and there is no early_fail. Pending attempts still resolve.
// - clr=1 at edge k:
//   * pend, pass_cnt, fail_cnt, first_fail_vld and first_fail_time are cleared.
//   * pass and fail are forced to 0.
//   * That edge's resolutions are discarded and no attempt starts.
//   clr has priority over all other updates.
// - Latency: early fail is reported 1 cycle after the a sample. Late results are reported
//   1 cycle after the b sample, i.e. DELAY+1 cycles after the a sample.
// - Every attempt started with en=1 produces exactly one pass or fail, unless rst or clr
//   intervenes.
// TESTING
// 1 Reset: rst=1 asserted between clock edges while pend!=0
//   -> all outputs 0 immediately, with no clock edge required; the pending attempt never reports.
// 2 DELAY=1, en=1: a=1 at edge 3, b=1 at edge 4 -> pass=1 after edge 4, pass_cnt=1, fail_cnt=1
//   (edge 4 also starts an attempt and needs a=1 for no fail; drive a=1 at 4 for fail_cnt=0).
// 3 en=1, a=0 at edge 2 (time_cnt=2)
//   -> fail=1 after edge 2, fail_cnt=1, first_fail_vld=1, first_fail_time=2.
// 4 DELAY=1: a=1 edge 5, then a=0 and b=0 at edge 6
//   -> fail_cnt increments by 2 at edge 6, pass=0, fail=1.
// 5 DELAY=3: a=1 at edges 10,11,12 and en=0 afterward; b=1,0,1 at edges 13,14,15
//   -> pass at 13, fail at 14, pass at 15; pass_cnt=2, fail_cnt=1.
// 6 CNT_W=4: 20 consecutive passes -> pass_cnt holds at 15.
//   Then clr=1 with an attempt pending -> counters 0, pending attempt dropped,
//   no pass/fail pulse afterward.

Source files
------------

// File: rtl/seq_a_then_b_monitor.sv
// Run-time checker for "a ##DELAY b": every enabled cycle starts one attempt that
// resolves to exactly one pass or fail. Keeps saturating counters and the first-fail time.
module seq_a_then_b_monitor #(
   parameter int DELAY = 1,
   parameter int CNT_W = 16,
   parameter int TS_W  = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic             a,
   input  logic             b,
   output logic             pass,
   output logic             fail,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             first_fail_vld,
   output logic [TS_W-1:0]  first_fail_time
);

   logic [TS_W-1:0]  time_q;
   logic [DELAY-1:0] pend_q, pend_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             ffv_q, ffv_d;
   logic [TS_W-1:0]  fft_q, fft_d;

   logic             early_fail;
   logic             late_pass;
   logic             late_fail;
   logic [1:0]       fail_inc;
   logic [CNT_W:0]   pass_sum;
   logic [CNT_W:0]   fail_sum;

   // Resolution of the attempt started now (a=0) and the one started DELAY edges ago
   always_comb begin
      early_fail = en & ~a;
      late_pass  = pend_q[DELAY-1] & b;
      late_fail  = pend_q[DELAY-1] & ~b;
      fail_inc   = {1'b0, early_fail} + {1'b0, late_fail};
      pass_sum   = {1'b0, pass_cnt_q} + (CNT_W+1)'(late_pass);
      fail_sum   = {1'b0, fail_cnt_q} + (CNT_W+1)'(fail_inc);
   end

   // Next-state logic; clr overrides every other update
   always_comb begin
      pend_d     = pend_q;
      pass_d     = 1'b0;
      fail_d     = 1'b0;
      pass_cnt_d = pass_cnt_q;
      fail_cnt_d = fail_cnt_q;
      ffv_d      = ffv_q;
      fft_d      = fft_q;
      if (clr) begin
         pend_d     = '0;
         pass_cnt_d = '0;
         fail_cnt_d = '0;
         ffv_d      = 1'b0;
         fft_d      = '0;
      end else begin
         pend_d[0] = en & a;
         for (int i = 1; i < DELAY; i++) begin
            pend_d[i] = pend_q[i-1];
         end
         pass_d = late_pass;
         fail_d = early_fail | late_fail;
         // Counters hold at all-ones once the carry out would wrap them
         if (pass_sum[CNT_W]) begin
            pass_cnt_d = '1;
         end else begin
            pass_cnt_d = pass_sum[CNT_W-1:0];
         end
         if (fail_sum[CNT_W]) begin
            fail_cnt_d = '1;
         end else begin
            fail_cnt_d = fail_sum[CNT_W-1:0];
         end
         if (!ffv_q && (early_fail || late_fail)) begin
            ffv_d = 1'b1;
            fft_d = time_q;
         end else begin
            ffv_d = ffv_q;
            fft_d = fft_q;
         end
      end
   end

   // Free-running timestamp, untouched by clr
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         time_q <= '0;
      end else begin
         time_q <= time_q + TS_W'(1);
      end
   end

   // Checker state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q     <= '0;
         pass_q     <= 1'b0;
         fail_q     <= 1'b0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
         ffv_q      <= 1'b0;
         fft_q      <= '0;
      end else begin
         pend_q     <= pend_d;
         pass_q     <= pass_d;
         fail_q     <= fail_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
         ffv_q      <= ffv_d;
         fft_q      <= fft_d;
      end
   end

   assign pass            = pass_q;
   assign fail            = fail_q;
   assign pass_cnt        = pass_cnt_q;
   assign fail_cnt        = fail_cnt_q;
   assign first_fail_vld  = ffv_q;
   assign first_fail_time = fft_q;

endmodule

// File: tb/tb_seq_a_then_b_monitor.sv
// Bench for seq_a_then_b_monitor: two instances (DELAY=1/CNT_W=16 and DELAY=3/CNT_W=4)
// share stimulus; each is compared to an attempt-level reference model every cycle.
module tb_seq_a_then_b_monitor;

   logic clk = 1'b0;
   logic rst, en, clr, a, b;

   logic        pass1, fail1, ffv1;
   logic [15:0] pc1, fc1;
   logic [31:0] fft1;
   logic        pass3, fail3, ffv3;
   logic [3:0]  pc3, fc3;
   logic [31:0] fft3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seq_a_then_b_monitor #(.DELAY(1), .CNT_W(16), .TS_W(32)) u1 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
      .pass(pass1), .fail(fail1), .pass_cnt(pc1), .fail_cnt(fc1),
      .first_fail_vld(ffv1), .first_fail_time(fft1));

   seq_a_then_b_monitor #(.DELAY(3), .CNT_W(4), .TS_W(32)) u3 (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
      .pass(pass3), .fail(fail3), .pass_cnt(pc3), .fail_cnt(fc3),
      .first_fail_vld(ffv3), .first_fail_time(fft3));

   // Reference model: attempts recorded by start edge, resolved DELAY edges later
   localparam int HIST = 4096;
   int          dly  [2] = '{1, 3};
   int          maxc [2] = '{65535, 15};
   bit          starts [2][HIST];
   int          k;
   int          last_clr;
   bit          m_p [2], m_f [2], m_ffv [2];
   int          m_pc [2], m_fc [2];
   logic [31:0] m_fft [2];

   typedef struct {
      logic en, clr, a, b;
      logic p, f;
      int   pc, fc;
      logic ffv;
      int   fft;
   } vec_t;
   vec_t tbl [12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < 2; j++) begin
         for (int h = 0; h < HIST; h++) starts[j][h] = 1'b0;
         m_p[j] = 1'b0; m_f[j] = 1'b0; m_ffv[j] = 1'b0;
         m_pc[j] = 0; m_fc[j] = 0; m_fft[j] = 32'd0;
      end
      k = 0;
      last_clr = -1;
   endtask

   task automatic model_edge();
      for (int j = 0; j < 2; j++) begin
         int s;
         bit lp, lf, ef;
         s  = k - dly[j];
         lp = 1'b0;
         lf = 1'b0;
         ef = en & ~a;
         if (s >= 0 && starts[j][s] && last_clr <= s) begin
            lp = b;
            lf = ~b;
         end
         if (clr) begin
            m_p[j] = 1'b0; m_f[j] = 1'b0; m_pc[j] = 0; m_fc[j] = 0;
            m_ffv[j] = 1'b0; m_fft[j] = 32'd0;
         end else begin
            m_p[j]  = lp;
            m_f[j]  = ef | lf;
            m_pc[j] = (m_pc[j] + int'(lp) > maxc[j]) ? maxc[j] : m_pc[j] + int'(lp);
            m_fc[j] = (m_fc[j] + int'(ef) + int'(lf) > maxc[j]) ? maxc[j]
                      : m_fc[j] + int'(ef) + int'(lf);
            if (!m_ffv[j] && (ef || lf)) begin
               m_ffv[j] = 1'b1;
               m_fft[j] = 32'(k);
            end
         end
         if (k < HIST) starts[j][k] = en & a & ~clr;
      end
      if (clr) last_clr = k;
      k++;
   endtask

   task automatic check_models();
      chk("d1_pass",  pass1, m_p[0]);
      chk("d1_fail",  fail1, m_f[0]);
      chk("d1_pcnt",  pc1,   m_pc[0]);
      chk("d1_fcnt",  fc1,   m_fc[0]);
      chk("d1_ffv",   ffv1,  m_ffv[0]);
      chk("d1_ftime", fft1,  m_fft[0]);
      chk("d3_pass",  pass3, m_p[1]);
      chk("d3_fail",  fail3, m_f[1]);
      chk("d3_pcnt",  pc3,   m_pc[1]);
      chk("d3_fcnt",  fc3,   m_fc[1]);
      chk("d3_ffv",   ffv3,  m_ffv[1]);
      chk("d3_ftime", fft3,  m_fft[1]);
   endtask

   // Called at a negedge; returns at the following negedge
   task automatic step(input logic e, input logic c, input logic av, input logic bv);
      en = e; clr = c; a = av; b = bv;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_models();
   endtask

   task automatic do_reset();
      @(negedge clk);
      en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      //            en    clr   a     b     p     f     pc fc ffv   fft
      tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 1'b0, 0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, 1, 1'b1, 3};
      tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 1'b1, 3};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 3, 1'b1, 3};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 1'b1, 3};
      tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 3, 1'b1, 3};
      tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1'b1, 10};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 2, 1'b1, 10};

      rst = 1'b1; en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b0;
      model_reset();
      #1;
      chk("rst_pass", pass1, 1'b0);
      chk("rst_fcnt", fc3, 4'd0);
      do_reset();
      check_models();

      // Directed table on the DELAY=1 instance, edge numbering from reset release
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].en, tbl[i].clr, tbl[i].a, tbl[i].b);
         chk($sformatf("tbl%0d_pass", i),  pass1, tbl[i].p);
         chk($sformatf("tbl%0d_fail", i),  fail1, tbl[i].f);
         chk($sformatf("tbl%0d_pcnt", i),  pc1,   16'(tbl[i].pc));
         chk($sformatf("tbl%0d_fcnt", i),  fc1,   16'(tbl[i].fc));
         chk($sformatf("tbl%0d_ffv", i),   ffv1,  tbl[i].ffv);
         chk($sformatf("tbl%0d_ftime", i), fft1,  32'(tbl[i].fft));
      end

      // DELAY=3: three starts, then b=1,0,1 with en=0
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("d3seq_pass13", pass3, 1'b1);
      chk("d3seq_fail13", fail3, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("d3seq_pass14", pass3, 1'b0);
      chk("d3seq_fail14", fail3, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("d3seq_pass15", pass3, 1'b1);
      chk("d3seq_pcnt", pc3, 4'd2);
      chk("d3seq_fcnt", fc3, 4'd1);

      // Saturation at CNT_W=4, then clr with attempts pending
      do_reset();
      for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
      chk("sat_pcnt", pc3, 4'd15);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      chk("clr_pcnt", pc3, 4'd0);
      chk("clr_pass", pass3, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk("postclr_pass", pass3, 1'b0);
         chk("postclr_fail", fail3, 1'b0);
      end

      // Randomised traffic against the model
      do_reset();
      for (int i = 0; i < 800; i++) begin
         step(logic'($urandom_range(3) != 0), logic'($urandom_range(39) == 0),
              logic'($urandom_range(1)), logic'($urandom_range(1)));
      end

      // Asynchronous reset mid-attempt: counters nonzero and attempts pending
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk("arst_fail1", fail1, 1'b0);
      chk("arst_fcnt1", fc1, 16'd0);
      chk("arst_fcnt3", fc3, 4'd0);
      chk("arst_ffv3",  ffv3, 1'b0);
      chk("arst_fft1",  fft1, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      en = 1'b0; clr = 1'b0; a = 1'b0; b = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         chk("arst_nopass3", pass3, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
